// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer: line sync, oversample tick, frame FSM, output word buffer.
// Optional break detection is built when UART_RX_CTRL_BREAK_DET_EN is defined.
module uart_rx_ctrl #(
  parameter int WIDTH      = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic [1:0]           sel,
  output logic                 shift_bit,
  output logic                 parity_load,
  output logic                 check_stop,
  output logic                 busy,
  output logic [WIDTH-1:0]     data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err
`ifdef UART_RX_CTRL_BREAK_DET_EN
  ,
  output logic                 break_det
`endif
);

  // state        | meaning
  // S_IDLE       | line idle, waiting for a falling edge
  // S_START      | validating start bit at mid-bit
  // S_DATA       | sampling WIDTH data bits, LSB first
  // S_PARITY     | sampling the parity bit
  // S_STOP       | sampling the stop bit, leaves at mid-bit
  // S_BREAK_WAIT | break seen, waiting for the line to return high
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
`ifdef UART_RX_CTRL_BREAK_DET_EN
    , S_BREAK_WAIT
`endif
  } state_t;

  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(WIDTH);
  localparam logic [OSW-1:0] OS_MID   = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);

  state_t               state_q, state_d;
  logic                 sync_q, rxs_q, rxs_prev_q;
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d, div_q, div_d;
  logic [OSW-1:0]       os_cnt_q, os_cnt_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                 par_en_q, par_en_d, par_odd_q, par_odd_d;
  logic [WIDTH-1:0]     shreg_q, shreg_d;
  logic                 par_err_n_q, par_err_n_d;
  logic [1:0]           sel_q, sel_d;
  logic                 shift_q, shift_d, pload_q, pload_d, cstop_q, cstop_d;
  logic                 busy_q, busy_d;
  logic [WIDTH-1:0]     dout_q, dout_d;
  logic                 dvalid_q, dvalid_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic                 tick, mid, bnd, complete, brk;
`ifdef UART_RX_CTRL_BREAK_DET_EN
  logic                 par_bit_q, par_bit_d, brk_q, brk_d;
`endif

  assign tick = (div_cnt_q == div_q);
  assign mid  = tick && (os_cnt_q == OS_MID);
  assign bnd  = tick && (os_cnt_q == OS_LAST);

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = '0;
    os_cnt_d    = '0;
    bit_cnt_d   = bit_cnt_q;
    div_d       = div_q;
    par_en_d    = par_en_q;
    par_odd_d   = par_odd_q;
    shreg_d     = shreg_q;
    par_err_n_d = par_err_n_q;
    shift_d     = 1'b0;
    pload_d     = 1'b0;
    cstop_d     = 1'b0;
    complete    = 1'b0;
    brk         = 1'b0;
`ifdef UART_RX_CTRL_BREAK_DET_EN
    par_bit_d   = par_bit_q;
    brk_d       = 1'b0;
`endif
    if (state_q != S_IDLE) begin
      div_cnt_d = tick ? '0 : div_cnt_q + DIV_WIDTH'(1);
      os_cnt_d  = tick ? os_cnt_q + OSW'(1) : os_cnt_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (rxs_prev_q && !rxs_q) begin
          state_d     = S_START;
          div_d       = baud_div;
          par_en_d    = parity_en;
          par_odd_d   = parity_odd;
          par_err_n_d = 1'b0;
          bit_cnt_d   = '0;
        end
      end
      S_START: begin
        if (mid && rxs_q) begin
          state_d = S_IDLE;
        end else if (bnd) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (mid) begin
          shift_d = 1'b1;
          shreg_d = {rxs_q, shreg_q[WIDTH-1:1]};
        end
        if (bnd) begin
          if (bit_cnt_q == BIT_LAST) state_d = par_en_q ? S_PARITY : S_STOP;
          else                       bit_cnt_d = bit_cnt_q + BCW'(1);
        end
      end
      S_PARITY: begin
        if (mid) begin
          pload_d     = 1'b1;
          par_err_n_d = ^shreg_q ^ rxs_q ^ par_odd_q;
`ifdef UART_RX_CTRL_BREAK_DET_EN
          par_bit_d   = rxs_q;
`endif
        end
        if (bnd) state_d = S_STOP;
      end
      S_STOP: begin
        // Leave at mid-stop so the next start edge is seen even on back-to-back frames.
        if (mid) begin
          cstop_d  = 1'b1;
          complete = 1'b1;
          state_d  = S_IDLE;
        end
      end
`ifdef UART_RX_CTRL_BREAK_DET_EN
      S_BREAK_WAIT: begin
        if (rxs_q) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

`ifdef UART_RX_CTRL_BREAK_DET_EN
    brk = complete && (shreg_q == '0) && !rxs_q && !(par_en_q && par_bit_q);
    if (brk) begin
      state_d = S_BREAK_WAIT;
      brk_d   = 1'b1;
    end
`endif

    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    ovr_d    = 1'b0;
    if (dvalid_q && data_ready) begin
      dvalid_d = 1'b0;
      perr_d   = 1'b0;
      ferr_d   = 1'b0;
    end
    if (complete && !brk) begin
      if (dvalid_q && !data_ready) begin
        ovr_d = 1'b1;
      end else begin
        dout_d   = shreg_q;
        perr_d   = par_err_n_q;
        ferr_d   = ~rxs_q;
        dvalid_d = 1'b1;
      end
    end

    // sel follows the state that raised the strobe, so each strobe sees its own select.
    unique case (state_q)
      S_DATA:   sel_d = 2'b01;
      S_PARITY: sel_d = 2'b10;
      S_STOP:   sel_d = 2'b11;
      default:  sel_d = 2'b00;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sync_q      <= 1'b1;
      rxs_q       <= 1'b1;
      rxs_prev_q  <= 1'b1;
      div_cnt_q   <= '0;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      div_q       <= '0;
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      shreg_q     <= '0;
      par_err_n_q <= 1'b0;
      sel_q       <= 2'b00;
      shift_q     <= 1'b0;
      pload_q     <= 1'b0;
      cstop_q     <= 1'b0;
      busy_q      <= 1'b0;
      dout_q      <= '0;
      dvalid_q    <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
`ifdef UART_RX_CTRL_BREAK_DET_EN
      par_bit_q   <= 1'b0;
      brk_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync_q      <= rx_in;
      rxs_q       <= sync_q;
      rxs_prev_q  <= rxs_q;
      div_cnt_q   <= div_cnt_d;
      os_cnt_q    <= os_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      div_q       <= div_d;
      par_en_q    <= par_en_d;
      par_odd_q   <= par_odd_d;
      shreg_q     <= shreg_d;
      par_err_n_q <= par_err_n_d;
      sel_q       <= sel_d;
      shift_q     <= shift_d;
      pload_q     <= pload_d;
      cstop_q     <= cstop_d;
      busy_q      <= busy_d;
      dout_q      <= dout_d;
      dvalid_q    <= dvalid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
`ifdef UART_RX_CTRL_BREAK_DET_EN
      par_bit_q   <= par_bit_d;
      brk_q       <= brk_d;
`endif
    end
  end

  assign sel         = sel_q;
  assign shift_bit   = shift_q;
  assign parity_load = pload_q;
  assign check_stop  = cstop_q;
  assign busy        = busy_q;
  assign data_out    = dout_q;
  assign data_valid  = dvalid_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign overrun_err = ovr_q;
`ifdef UART_RX_CTRL_BREAK_DET_EN
  assign break_det   = brk_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed bench for uart_rx_ctrl; serial frames are driven on rx_in and
// strobes/handshakes are tallied by a negedge monitor, then checked at fixed points.
module tb_uart_rx_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_in = 1'b1;
  logic [15:0] baud_div = 16'd0;
  logic        parity_en = 1'b0;
  logic        parity_odd = 1'b0;
  logic        data_ready = 1'b1;
  logic [1:0]  sel;
  logic        shift_bit, parity_load, check_stop, busy;
  logic [7:0]  data_out;
  logic        data_valid, parity_err, frame_err, overrun_err;
`ifdef UART_RX_CTRL_BREAK_DET_EN
  logic        break_det;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0, last_shift = -1;
  int n_shift = 0, n_par = 0, n_stop = 0, n_busy = 0, n_vcyc = 0, n_ovr = 0, n_xfer = 0;
  int good_gap = 0, odd_gap = 0, n_viol = 0;
  logic [7:0] last_data = 8'h00;
  logic       last_perr = 1'b0, last_ferr = 1'b0;

  int b_shift, b_par, b_stop, b_busy, b_vcyc, b_ovr, b_xfer, b_good, b_odd;

  always #5 clk = ~clk;

  uart_rx_ctrl dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .baud_div(baud_div),
    .parity_en(parity_en), .parity_odd(parity_odd), .sel(sel),
    .shift_bit(shift_bit), .parity_load(parity_load), .check_stop(check_stop),
    .busy(busy), .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun_err(overrun_err)
`ifdef UART_RX_CTRL_BREAK_DET_EN
    , .break_det(break_det)
`endif
  );

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (shift_bit) begin
        if (last_shift >= 0 && cyc - last_shift < 40) begin
          if (cyc - last_shift == 16) good_gap = good_gap + 1;
          else                        odd_gap  = odd_gap + 1;
        end
        last_shift = cyc;
        n_shift = n_shift + 1;
      end
      if (parity_load) n_par  = n_par + 1;
      if (check_stop)  n_stop = n_stop + 1;
      if (busy)        n_busy = n_busy + 1;
      if (data_valid)  n_vcyc = n_vcyc + 1;
      if (overrun_err) n_ovr  = n_ovr + 1;
      if (data_valid && data_ready) begin
        n_xfer    = n_xfer + 1;
        last_data = data_out;
        last_perr = parity_err;
        last_ferr = frame_err;
      end
      if ((shift_bit && sel != 2'b01) || (parity_load && sel != 2'b10) ||
          (check_stop && sel != 2'b11))
        n_viol = n_viol + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    b_shift = n_shift; b_par = n_par; b_stop = n_stop; b_busy = n_busy;
    b_vcyc = n_vcyc; b_ovr = n_ovr; b_xfer = n_xfer; b_good = good_gap; b_odd = odd_gap;
  endtask

  // scr: after the start edge, disturb the config inputs to show they are latched per frame
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb, input bit scr);
    int bc;
    logic pen;
    logic [15:0] sv_div;
    logic sv_pen, sv_odd;
    bc = 16 * (int'(baud_div) + 1);
    pen = parity_en;
    sv_div = baud_div; sv_pen = parity_en; sv_odd = parity_odd;
    rx_in = 1'b0;
    cycles(8);
    if (scr) begin
      baud_div = baud_div ^ 16'h0005;
      parity_en = ~parity_en;
      parity_odd = ~parity_odd;
    end
    cycles(bc - 8);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      cycles(bc);
    end
    if (pen) begin
      rx_in = pbit;
      cycles(bc);
    end
    rx_in = stopb;
    cycles(bc);
    rx_in = 1'b1;
    baud_div = sv_div; parity_en = sv_pen; parity_odd = sv_odd;
  endtask

  initial begin
    rst = 1'b1;
    cycles(3);
    chk("rst_sel", sel, 2'b00);
    chk("rst_shift", shift_bit, 1'b0);
    chk("rst_pload", parity_load, 1'b0);
    chk("rst_cstop", check_stop, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dout", data_out, 8'h00);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_perr", parity_err, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_ovr", overrun_err, 1'b0);
    rst = 1'b0;
    cycles(5);

    // 0xA5 8N1 at one tick per clock
    snap();
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    cycles(20);
    chk("a5_data", last_data, 8'hA5);
    chk("a5_xfer", n_xfer - b_xfer, 1);
    chk("a5_valid_cycles", n_vcyc - b_vcyc, 1);
    chk("a5_shifts", n_shift - b_shift, 8);
    chk("a5_gap16", good_gap - b_good, 7);
    chk("a5_gap_other", odd_gap - b_odd, 0);
    chk("a5_stops", n_stop - b_stop, 1);
    chk("a5_pload", n_par - b_par, 0);
    chk("a5_perr", last_perr, 1'b0);
    chk("a5_ferr", last_ferr, 1'b0);
    chk("a5_idle_busy", busy, 1'b0);

    // parity at baud_div=3
    baud_div = 16'd3; parity_en = 1'b1; parity_odd = 1'b0;
    snap();
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    cycles(20);
    chk("par_even_bad_data", last_data, 8'h3C);
    chk("par_even_bad_perr", last_perr, 1'b1);
    chk("par_even_bad_pload", n_par - b_par, 1);
    chk("par_even_bad_xfer", n_xfer - b_xfer, 1);
    snap();
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
    cycles(20);
    chk("par_even_ok_data", last_data, 8'h3C);
    chk("par_even_ok_perr", last_perr, 1'b0);
    chk("par_even_ok_ferr", last_ferr, 1'b0);
    chk("par_even_ok_xfer", n_xfer - b_xfer, 1);
    parity_odd = 1'b1;
    snap();
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    cycles(20);
    chk("par_odd_bad_data", last_data, 8'h07);
    chk("par_odd_bad_perr", last_perr, 1'b1);

    // 4-clock glitch is a false start
    baud_div = 16'd0; parity_en = 1'b0; parity_odd = 1'b0;
    snap();
    rx_in = 1'b0;
    cycles(4);
    rx_in = 1'b1;
    cycles(14);
    chk("glitch_busy_end", busy, 1'b0);
    chk("glitch_busy_seen", (n_busy - b_busy) > 0, 1'b1);
    chk("glitch_shifts", n_shift - b_shift, 0);
    chk("glitch_stops", n_stop - b_stop, 0);
    chk("glitch_valid", data_valid, 1'b0);

    // stop bit low gives a framing error, cleared by the handshake
    data_ready = 1'b0;
    snap();
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    cycles(20);
    chk("ferr_valid", data_valid, 1'b1);
    chk("ferr_flag", frame_err, 1'b1);
    chk("ferr_perr", parity_err, 1'b0);
    chk("ferr_data", data_out, 8'h55);
    data_ready = 1'b1;
    cycles(1);
    data_ready = 1'b0;
    chk("ferr_valid_clr", data_valid, 1'b0);
    chk("ferr_flag_clr", frame_err, 1'b0);
    chk("ferr_xfer", n_xfer - b_xfer, 1);
    chk("ferr_xfer_flag", last_ferr, 1'b1);

    // overrun: second word dropped while the first is unconsumed
    snap();
    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    cycles(20);
    chk("ovr_data", data_out, 8'h11);
    chk("ovr_valid", data_valid, 1'b1);
    chk("ovr_pulses", n_ovr - b_ovr, 1);
    chk("ovr_ferr", frame_err, 1'b0);
    data_ready = 1'b1;
    cycles(1);
    data_ready = 1'b0;
    chk("ovr_valid_clr", data_valid, 1'b0);
    chk("ovr_xfer", n_xfer - b_xfer, 1);
    chk("ovr_xfer_data", last_data, 8'h11);
    data_ready = 1'b1;
    cycles(5);

    // reset during data bit 4 of an all-ones frame
    snap();
    rx_in = 1'b0;
    cycles(16);
    rx_in = 1'b1;
    cycles(64 + 6);
    chk("mid_busy", busy, 1'b1);
    chk("mid_sel", sel, 2'b01);
    rst = 1'b1;
    cycles(1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_sel", sel, 2'b00);
    chk("mid_rst_dout", data_out, 8'h00);
    chk("mid_rst_valid", data_valid, 1'b0);
    chk("mid_rst_shift", shift_bit, 1'b0);
    rst = 1'b0;
    cycles(40);
    chk("mid_rst_shifts", n_shift - b_shift, 4);
    chk("mid_rst_no_word", n_xfer - b_xfer, 0);
    snap();
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    cycles(20);
    chk("post_rst_data", last_data, 8'hF0);
    chk("post_rst_xfer", n_xfer - b_xfer, 1);
    chk("post_rst_ferr", last_ferr, 1'b0);

    chk("strobe_sel_match", n_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
